// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the MIPS32 instruction fetch stage.
//   NOP_WORD_DEF  : default bubble instruction word
//   RESET_PC_DEF  : default PC after reset
//   fetch_entry_t : one queued fetch result {instr, pc4}
//   word_align    : clears the byte-offset bits of an address
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bus.
//   IM_Req/IM_Addr  : fetch request and word-aligned byte address
//   IM_Ready        : memory accepts the request this cycle
//   IM_Valid/IM_Data: in-order response word
// master = fetch unit, slave = instruction memory.
interface instruction_fetch_unit_if;

  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic        IM_Valid;
  logic [31:0] IM_Data;

  modport master (output IM_Req, IM_Addr, input IM_Ready, IM_Valid, IM_Data);
  modport slave  (input IM_Req, IM_Addr, output IM_Ready, IM_Valid, IM_Data);

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush and same-cycle push/pop.
//   clk_i       : clock
//   flush_i     : empties the FIFO (wins over push/pop)
//   push_i      : write push_data_i (ignored when full unless popping)
//   pop_i       : drop the head entry (ignored when empty)
//   head_o      : oldest entry, valid while empty_o=0
//   count_o     : number of stored entries
//   empty_o     : no entries stored
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ((count_q != FULL_C) | do_pop);

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS32 IF stage: owns the PC, issues in-order fetches, buffers returned
// words and drives the IF/ID pipeline register.
//   Clk, Rst_n         : clock, synchronous active-low reset
//   im                 : instruction memory bus (master side)
//   ID_stall           : decode stall, IF/ID holds
//   ID_PCSrc/ID_new_PC : taken branch/jump and its target
//   IF_ID_*            : instruction, its address + 4, valid (0 = bubble)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          FQ_DEPTH = 4,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  instruction_fetch_unit_if.master  im,
  input  logic                      ID_stall,
  input  logic                      ID_PCSrc,
  input  logic [31:0]               ID_new_PC,
  output logic [31:0]               IF_ID_Instruction,
  output logic [31:0]               IF_ID_PC4,
  output logic                      IF_ID_Valid
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   if_instr_q, if_instr_d, if_pc4_q, if_pc4_d;
  logic          if_valid_q, if_valid_d;

  fetch_entry_t  q_head, q_push_data;
  logic [CW-1:0] q_count, pc4_count, outstanding;
  logic [31:0]   pc4_head;
  logic          q_empty, pc4_empty, q_push, q_pop, flush;
  logic          redirect, cap_ok, accept, rsp_any, resp_stale, resp_live, bypass;

  // The pc4 FIFO holds one entry per live (non-discarded) request, so its
  // count plus the discard count is the total number of requests in flight.
  assign outstanding = pc4_count + discard_q;
  assign redirect    = ID_PCSrc & if_valid_q & ~ID_stall;
  assign cap_ok      = ({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C;
  assign im.IM_Req   = Rst_n & ~redirect & cap_ok;
  assign im.IM_Addr  = pc_q;
  assign accept      = im.IM_Req & im.IM_Ready;
  assign rsp_any     = im.IM_Valid & (outstanding != '0);
  assign resp_stale  = im.IM_Valid & (discard_q != '0);
  assign resp_live   = im.IM_Valid & (discard_q == '0) & ~pc4_empty;
  assign bypass      = ~ID_stall & ~redirect & q_empty & resp_live;
  assign q_push      = resp_live & ~redirect & ~bypass;
  assign q_pop       = ~ID_stall & ~redirect & ~q_empty;
  assign flush       = ~Rst_n | redirect;
  assign q_push_data = '{instr: im.IM_Data, pc4: pc4_head};

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_data_q (
    .clk_i(Clk), .flush_i(flush), .push_i(q_push), .push_data_i(q_push_data),
    .pop_i(q_pop), .head_o(q_head), .count_o(q_count), .empty_o(q_empty)
  );

  // Flushed together with the data queue: every pre-flush request becomes a
  // discarded response and never needs its pc4.
  fetch_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) u_pc4_q (
    .clk_i(Clk), .flush_i(flush), .push_i(accept), .push_data_i(pc_q + 32'd4),
    .pop_i(resp_live), .head_o(pc4_head), .count_o(pc4_count), .empty_o(pc4_empty)
  );

  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc4_d   = if_pc4_q;
    if_valid_d = if_valid_q;
    discard_d  = discard_q - CW'(resp_stale);

    // On reset or redirect every request still in flight after this edge is
    // dropped; a response landing at this edge is already accounted for.
    if (!Rst_n || redirect) discard_d = outstanding - CW'(rsp_any);

    if (redirect)    pc_d = word_align(ID_new_PC);
    else if (accept) pc_d = pc_q + 32'd4;

    if (!ID_stall) begin
      if_instr_d = NOP_WORD;
      if_pc4_d   = '0;
      if_valid_d = 1'b0;
      if (!redirect) begin
        if (!q_empty) begin
          if_instr_d = q_head.instr;
          if_pc4_d   = q_head.pc4;
          if_valid_d = 1'b1;
        end else if (resp_live) begin
          if_instr_d = im.IM_Data;
          if_pc4_d   = pc4_head;
          if_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      pc_q       <= RESET_PC;
      if_instr_q <= NOP_WORD;
      if_pc4_q   <= '0;
      if_valid_q <= 1'b0;
      discard_q  <= discard_d;  // keeps tracking stale words through reset
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc4_q   <= if_pc4_d;
      if_valid_q <= if_valid_d;
      discard_q  <= discard_d;
    end
  end

  assign IF_ID_Instruction = if_instr_q;
  assign IF_ID_PC4         = if_pc4_q;
  assign IF_ID_Valid       = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order latency memory model plus a
// program-order reference (expected next instruction address and expected
// fetch address), driven by directed scenarios and a randomized run.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ID_stall = 1'b0;
  logic        ID_PCSrc = 1'b0;
  logic [31:0] ID_new_PC = '0;
  logic [31:0] IF_ID_Instruction, IF_ID_PC4;
  logic        IF_ID_Valid;

  instruction_fetch_unit_if im_bus();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .NOP_WORD(32'h0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .im(im_bus),
    .ID_stall(ID_stall), .ID_PCSrc(ID_PCSrc), .ID_new_PC(ID_new_PC),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC4(IF_ID_PC4), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  int   lat = 1, cyc = 0, last_due = 0, inflight = 0, idle_cnt = 0;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc4, obs_instr;
  logic [31:0] exp_pc = RESET_PC, exp_fetch = RESET_PC;
  logic        first_flag = 1'b1, rst_prev = 1'b0, hold_pend = 1'b0, hold_valid;
  logic [31:0] hold_instr, hold_pc4;

  // One clock: observe and check at the falling edge, let the rising edge
  // happen, then update the memory model and drive its response.
  task automatic tick();
    logic acc, rsp, redir;
    logic [31:0] acc_addr;
    req_t r;
    @(negedge Clk);
    obs_req = im_bus.IM_Req;  obs_addr = im_bus.IM_Addr;
    obs_valid = IF_ID_Valid;  obs_pc4 = IF_ID_PC4;  obs_instr = IF_ID_Instruction;
    acc = obs_req & im_bus.IM_Ready;
    rsp = im_bus.IM_Valid;
    redir = Rst_n & ID_PCSrc & obs_valid & ~ID_stall;
    acc_addr = obs_addr;
    if (rst_prev) begin
      check_eq("reset_if_valid", {31'b0, obs_valid}, 32'd0);
      check_eq("reset_if_instr", obs_instr, 32'h0);
      check_eq("reset_if_pc4", obs_pc4, 32'h0);
    end
    if (!Rst_n) begin
      check_eq("req_in_reset", {31'b0, obs_req}, 32'd0);
      exp_pc = RESET_PC;  exp_fetch = RESET_PC;  first_flag = 1'b1;  idle_cnt = 0;
    end else begin
      check_eq("fetch_addr", obs_addr, exp_fetch);
      check_eq("inflight_le_depth", {31'b0, inflight <= FQ_DEPTH}, 32'd1);
      if (hold_pend) begin
        check_eq("stall_hold_valid", {31'b0, obs_valid}, {31'b0, hold_valid});
        check_eq("stall_hold_instr", obs_instr, hold_instr);
        check_eq("stall_hold_pc4", obs_pc4, hold_pc4);
      end
      if (redir) check_eq("no_req_on_redirect", {31'b0, obs_req}, 32'd0);
      if (obs_valid && first_flag) begin
        check_eq("first_after_reset_pc4", obs_pc4, RESET_PC + 32'd4);
        first_flag = 1'b0;
      end
      if (obs_valid && !ID_stall) begin
        check_eq("seq_pc4", obs_pc4, exp_pc + 32'd4);
        check_eq("seq_instr", obs_instr, mem_word(exp_pc));
        exp_pc = ID_PCSrc ? {ID_new_PC[31:2], 2'b00} : exp_pc + 32'd4;
        idle_cnt = 0;
      end else begin
        idle_cnt++;
        if (idle_cnt > 100) begin
          check_eq("progress_idle_cycles", idle_cnt, 32'd100);
          idle_cnt = 0;
        end
      end
      if (redir)    exp_fetch = {ID_new_PC[31:2], 2'b00};
      else if (acc) exp_fetch = exp_fetch + 32'd4;
    end
    hold_pend = Rst_n & ID_stall;
    hold_valid = obs_valid;  hold_instr = obs_instr;  hold_pc4 = obs_pc4;
    rst_prev = ~Rst_n;
    inflight = inflight + int'(acc) - int'(rsp);
    @(posedge Clk);
    cyc++;
    #1;
    if (acc) begin
      r.addr = acc_addr;
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      mq.push_back(r);
    end
    if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
      im_bus.IM_Valid = 1'b1;
      im_bus.IM_Data = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      im_bus.IM_Valid = 1'b0;
      im_bus.IM_Data = $urandom;
    end
  endtask

  initial begin
    bit found;
    im_bus.IM_Ready = 1'b1;
    im_bus.IM_Valid = 1'b0;
    im_bus.IM_Data = '0;

    // Reset then run with a 1-cycle memory
    repeat (3) tick();
    Rst_n = 1'b1;
    tick(); check_eq("rr_addr0", obs_addr, 32'h0); check_eq("rr_req0", {31'b0, obs_req}, 32'd1);
    tick(); check_eq("rr_addr1", obs_addr, 32'h4);
    tick(); check_eq("rr_addr2", obs_addr, 32'h8);
    check_eq("rr_if0_valid", {31'b0, obs_valid}, 32'd1);
    check_eq("rr_if0_pc4", obs_pc4, 32'h4); check_eq("rr_if0_instr", obs_instr, 32'd0);
    tick(); check_eq("rr_if1_pc4", obs_pc4, 32'h8); check_eq("rr_if1_instr", obs_instr, 32'd1);

    // Stall while IF/ID holds the word from 0x8
    check_eq("st_setup_pc4", IF_ID_PC4, 32'hC);
    ID_stall = 1'b1;
    repeat (3) begin tick(); check_eq("st_hold_pc4", obs_pc4, 32'hC); end
    ID_stall = 1'b0;
    tick(); check_eq("st_req_drop", {31'b0, obs_req}, 32'd0); check_eq("st_rel_pc4", obs_pc4, 32'hC);
    tick(); check_eq("st_next_pc4", obs_pc4, 32'h10);

    // Taken branch at 0x10 to 0x40
    check_eq("br_setup_pc4", IF_ID_PC4, 32'h14);
    ID_PCSrc = 1'b1; ID_new_PC = 32'h0000_0042;
    tick(); ID_PCSrc = 1'b0;
    tick(); check_eq("br_bubble", {31'b0, obs_valid}, 32'd0); check_eq("br_pc", obs_addr, 32'h40);
    tick(); check_eq("br_bubble2", {31'b0, obs_valid}, 32'd0);
    tick(); check_eq("br_target_valid", {31'b0, obs_valid}, 32'd1);
    check_eq("br_target_pc4", obs_pc4, 32'h44);

    // Redirect with a 3-cycle memory and requests in flight
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (inflight >= 3 && IF_ID_Valid) found = 1'b1;
    end
    check_eq("rd3_setup", {31'b0, found}, 32'd1);
    ID_PCSrc = 1'b1; ID_new_PC = 32'h0000_0100;
    tick(); ID_PCSrc = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (obs_valid) found = 1'b1;
    end
    check_eq("rd3_target_pc4", obs_pc4, 32'h104);

    // IM_Ready low for 5 cycles
    lat = 1;
    repeat (6) tick();
    im_bus.IM_Ready = 1'b0;
    tick();
    begin
      logic [31:0] held;
      held = obs_addr;
      repeat (4) begin tick(); check_eq("rdy_addr_hold", obs_addr, held); end
    end
    check_eq("rdy_bubble", {31'b0, obs_valid}, 32'd0);
    im_bus.IM_Ready = 1'b1;
    repeat (10) tick();

    // Mid-stream reset with requests outstanding
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (inflight >= 2) found = 1'b1;
    end
    check_eq("mrst_setup", {31'b0, found}, 32'd1);
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    check_eq("mrst_pc", im_bus.IM_Addr, RESET_PC);
    repeat (25) tick();
    check_eq("mrst_resumed", {31'b0, first_flag}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 3);
      im_bus.IM_Ready = ($urandom_range(0, 9) < 7);
      ID_stall = ($urandom_range(0, 9) < 3);
      ID_PCSrc = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) ID_new_PC = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else ID_new_PC = $urandom_range(0, 1023);
      Rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    Rst_n = 1'b1; ID_stall = 1'b0; ID_PCSrc = 1'b0; im_bus.IM_Ready = 1'b1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
